// File: rtl/coin_seq_pkg.sv
// Shared types and defaults for the coin dispense sequencer: state encoding,
// timer defaults, servo direction constants and a counter-width helper.
package coin_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PUSH_ACK  = 3'd1,
      ST_PUSH_WAIT = 3'd2,
      ST_RET_ACK   = 3'd3,
      ST_RET_WAIT  = 3'd4,
      ST_SETTLE    = 3'd5,
      ST_FAULT     = 3'd6
   } state_e;

   localparam int unsigned DEF_MAX_COINS      = 15;
   localparam int unsigned DEF_SETTLE_CYCLES  = 1_000_000;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;

   localparam logic SERVO_BACK  = 1'b1;
   localparam logic SERVO_FRONT = 1'b0;

   // One width serves both timers so a single sub-module type covers them.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

   function automatic logic is_phase_state(input state_e s);
      return (s == ST_PUSH_ACK) || (s == ST_PUSH_WAIT) ||
             (s == ST_RET_ACK)  || (s == ST_RET_WAIT);
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable saturating down-counter. start loads load_val_i; expired_o is high
// while the count sits at zero, so a load of N-1 expires on the Nth cycle.
module seq_timer #(
   parameter int unsigned WIDTH = 26
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             expired_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (clr) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/coin_dispense_sequencer.sv
// Drives one push/return servo stroke per coin with a settle gap between coins.
// COIN_SEQ_TIMEOUT_EN adds a per-phase handshake timeout that latches FAULT.
module coin_dispense_sequencer
   import coin_seq_pkg::*;
#(
   parameter int unsigned MAX_COINS      = DEF_MAX_COINS,
   parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_valid,
   input  logic [3:0]  req_count,
   output logic        req_ready,
   output logic [31:0] servoCtrl,
   input  logic        servoBackDone,
   input  logic        servoFrontDone,
   output logic [3:0]  coins_dispensed,
   output logic        busy,
   output logic        done_pulse,
   output logic        fault
);

   localparam int unsigned   CW        = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
   localparam logic [3:0]    MAX_C     = (MAX_COINS > 15) ? 4'd15 : 4'(MAX_COINS);

   state_e     state_q, state_d;
   logic [3:0] target_q, target_d;
   logic [3:0] coins_q, coins_d;
   logic       servo_q, servo_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [3:0] req_tgt;
   logic       settle_start, settle_exp;
   logic       timeout;

   assign req_tgt = (req_count > MAX_C) ? MAX_C : req_count;

   seq_timer #(.WIDTH(CW)) u_settle (
      .clk        (clk),
      .clr        (clr),
      .start_i    (settle_start),
      .load_val_i (SETTLE_LD),
      .expired_o  (settle_exp)
   );

`ifdef COIN_SEQ_TIMEOUT_EN
   localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
   logic phase_start, phase_exp;
   logic fault_q;

   // Reload on every entry into an ACK/WAIT state, including ACK -> WAIT.
   assign phase_start = is_phase_state(state_d) && (state_d != state_q);

   seq_timer #(.WIDTH(CW)) u_timeout (
      .clk        (clk),
      .clr        (clr),
      .start_i    (phase_start),
      .load_val_i (TIMEOUT_LD),
      .expired_o  (phase_exp)
   );

   assign timeout = phase_exp;

   always_ff @(posedge clk) begin
      if (clr) fault_q <= 1'b0;
      else     fault_q <= (state_d == ST_FAULT);
   end

   assign fault = fault_q;
`else
   assign timeout = 1'b0;
   assign fault   = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      coins_d  = coins_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               target_d = req_tgt;
               coins_d  = '0;
               if (req_tgt == '0) done_d  = 1'b1;
               else               state_d = ST_PUSH_ACK;
            end
         end
         // A completion level wins over a timeout seen in the same cycle.
         ST_PUSH_ACK: begin
            if (!servoBackDone) state_d = ST_PUSH_WAIT;
            else if (timeout)   state_d = ST_FAULT;
         end
         ST_PUSH_WAIT: begin
            if (servoBackDone)  state_d = ST_RET_ACK;
            else if (timeout)   state_d = ST_FAULT;
         end
         ST_RET_ACK: begin
            if (!servoFrontDone) state_d = ST_RET_WAIT;
            else if (timeout)    state_d = ST_FAULT;
         end
         ST_RET_WAIT: begin
            if (servoFrontDone) begin
               coins_d = coins_q + 4'd1;
               if (coins_d == target_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_SETTLE;
               end
            end else if (timeout) begin
               state_d = ST_FAULT;
            end
         end
         ST_SETTLE: begin
            if (settle_exp) state_d = ST_PUSH_ACK;
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign settle_start = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      servo_d = ((state_d == ST_PUSH_ACK) || (state_d == ST_PUSH_WAIT)) ? SERVO_BACK : SERVO_FRONT;
      busy_d  = (state_d != ST_IDLE) && (state_d != ST_FAULT);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= ST_IDLE;
         target_q <= '0;
         coins_q  <= '0;
         servo_q  <= SERVO_FRONT;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         coins_q  <= coins_d;
         servo_q  <= servo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign req_ready       = (state_q == ST_IDLE) && !clr;
   assign servoCtrl       = {31'd0, servo_q};
   assign coins_dispensed = coins_q;
   assign busy            = busy_q;
   assign done_pulse      = done_q;

endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// Bench for coin_dispense_sequencer with a servo responder model and a stroke
// monitor; expectations come from request counts and the settle/timeout rules.
module tb_coin_dispense_sequencer;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 20;
   localparam int STROKE  = 10;

   logic        clk = 1'b0;
   logic        clr, req_valid, req_ready;
   logic [3:0]  req_count, coins_dispensed;
   logic [31:0] servoCtrl;
   logic        servoBackDone = 1'b1, servoFrontDone = 1'b1;
   logic        busy, done_pulse, fault;

   int vectors = 0, miscompares = 0;
   int cyc = 0;

   coin_dispense_sequencer #(
      .MAX_COINS      (15),
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk             (clk),
      .clr             (clr),
      .req_valid       (req_valid),
      .req_count       (req_count),
      .req_ready       (req_ready),
      .servoCtrl       (servoCtrl),
      .servoBackDone   (servoBackDone),
      .servoFrontDone  (servoFrontDone),
      .coins_dispensed (coins_dispensed),
      .busy            (busy),
      .done_pulse      (done_pulse),
      .fault           (fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Servo responder: flag drops one cycle after a bit-0 change, rises STROKE(+extra) later.
   logic resp_prev = 1'b0;
   logic never_drop = 1'b0;
   int   back_extra = 0;
   int   back_drop = -1, back_rise = -1, front_drop = -1, front_rise = -1;
   always @(negedge clk) begin
      if (cyc == back_drop)  servoBackDone  = 1'b0;
      if (cyc == back_rise)  servoBackDone  = 1'b1;
      if (cyc == front_drop) servoFrontDone = 1'b0;
      if (cyc == front_rise) servoFrontDone = 1'b1;
      if (servoCtrl[0] !== resp_prev) begin
         resp_prev = servoCtrl[0];
         if (resp_prev && !never_drop) begin
            back_drop = cyc + 1;
            back_rise = cyc + 1 + STROKE + back_extra;
         end else if (!resp_prev) begin
            front_drop = cyc + 1;
            front_rise = cyc + 1 + STROKE;
         end
      end
   end

   // Stroke monitor summarising what the DUT did since the last clear.
   logic mon_clr = 1'b0;
   logic prev_servo = 1'b0, prev_busy = 1'b0;
   logic [3:0] prev_coins = '0;
   int pushes, dones, incs, step_err, gap_cnt, gap_bad, busy_rises, coins_at_done, last_inc;
   always @(negedge clk) begin
      if (mon_clr) begin
         pushes = 0; dones = 0; incs = 0; step_err = 0; gap_cnt = 0; gap_bad = 0;
         busy_rises = 0; coins_at_done = -1; last_inc = -1;
      end else begin
         if (servoCtrl[0] && !prev_servo) begin
            pushes++;
            if (last_inc >= 0) begin
               gap_cnt++;
               if (cyc - last_inc != SETTLE) gap_bad++;
            end
         end
         if (coins_dispensed != prev_coins && coins_dispensed != 4'd0) begin
            incs++;
            last_inc = cyc;
            if (int'(coins_dispensed) != int'(prev_coins) + 1) step_err++;
         end
         if (done_pulse) begin
            dones++;
            coins_at_done = int'(coins_dispensed);
         end
         if (busy && !prev_busy) busy_rises++;
      end
      prev_servo = servoCtrl[0];
      prev_coins = coins_dispensed;
      prev_busy  = busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic mon_clear();
      mon_clr = 1'b1;
      step();
      mon_clr = 1'b0;
   endtask

   // Issue a request and check the cycle after acceptance.
   task automatic issue(input string tag, input int cnt);
      mon_clear();
      req_valid = 1'b1;
      req_count = 4'(cnt);
      #1;
      chk({tag, "_ready"}, req_ready, 1);
      step();
      req_valid = 1'b0;
      chk({tag, "_busy_t1"},  busy,            (cnt != 0) ? 1 : 0);
      chk({tag, "_servo_t1"}, servoCtrl,       (cnt != 0) ? 1 : 0);
      chk({tag, "_coins_t1"}, coins_dispensed, 0);
      chk({tag, "_done_t1"},  done_pulse,      (cnt == 0) ? 1 : 0);
   endtask

   // Wait (bounded) for completion and compare against the per-request model.
   task automatic finish_req(input string tag, input int cnt);
      int target, n;
      target = (cnt > 15) ? 15 : cnt;
      n = 0;
      while (dones == 0 && n < 3000) begin
         step();
         n++;
      end
      chk({tag, "_done_seen"}, (dones != 0) ? 1 : 0, 1);
      repeat (3) step();
      chk({tag, "_pushes"},     pushes,           target);
      chk({tag, "_dones"},      dones,            1);
      chk({tag, "_coins_done"}, coins_at_done,    target);
      chk({tag, "_incs"},       incs,             target);
      chk({tag, "_steps"},      step_err,         0);
      chk({tag, "_gaps"},       gap_cnt,          (target > 0) ? target - 1 : 0);
      chk({tag, "_gap_len"},    gap_bad,          0);
      chk({tag, "_idle_busy"},  busy,             0);
      chk({tag, "_idle_ready"}, req_ready,        1);
      chk({tag, "_hold_coins"}, coins_dispensed,  target);
      chk({tag, "_fault"},      fault,            0);
   endtask

   initial begin
      int cnt;
      clr = 1'b1;
      req_valid = 1'b0;
      req_count = 4'd0;
      repeat (3) step();
      chk("rst_ready", req_ready,       0);
      chk("rst_servo", servoCtrl,       0);
      chk("rst_coins", coins_dispensed, 0);
      chk("rst_busy",  busy,            0);
      chk("rst_done",  done_pulse,      0);
      chk("rst_fault", fault,           0);
      clr = 1'b0;
      step();
      chk("post_rst_ready", req_ready, 1);

      issue("three", 3);
      finish_req("three", 3);

      issue("zero", 0);
      step();
      chk("zero_done_once", done_pulse, 0);
      repeat (5) step();
      chk("zero_busy_rises", busy_rises, 0);
      chk("zero_servo", servoCtrl, 0);
      chk("zero_dones", dones, 1);

      issue("ignore", 2);
      repeat (3) step();
      req_valid = 1'b1;
      req_count = 4'd5;
      #1;
      chk("ignore_ready_busy", req_ready, 0);
      step();
      req_valid = 1'b0;
      finish_req("ignore", 2);

      for (int i = 0; i < 3; i++) begin
         cnt = int'($urandom_range(1, 5));
         issue("rand", cnt);
         finish_req("rand", cnt);
      end
      issue("max", 15);
      finish_req("max", 15);

      issue("clr", 2);
      repeat (4) step();
      clr = 1'b1;
      #1;
      chk("clr_ready_low", req_ready, 0);
      step();
      chk("clr_servo", servoCtrl,       0);
      chk("clr_coins", coins_dispensed, 0);
      chk("clr_busy",  busy,            0);
      chk("clr_done",  done_pulse,      0);
      chk("clr_fault", fault,           0);
      clr = 1'b0;
      #1;
      chk("clr_ready_after", req_ready, 1);
      repeat (30) step();

`ifdef COIN_SEQ_TIMEOUT_EN
      never_drop = 1'b1;
      issue("tmo", 1);
      repeat (19) step();
      chk("tmo_pre_fault", fault, 0);
      chk("tmo_pre_servo", servoCtrl, 1);
      step();
      chk("tmo_fault", fault,     1);
      chk("tmo_servo", servoCtrl, 0);
      chk("tmo_busy",  busy,      0);
      chk("tmo_ready", req_ready, 0);
      req_valid = 1'b1;
      req_count = 4'd1;
      repeat (5) step();
      chk("tmo_sticky_ready", req_ready, 0);
      chk("tmo_sticky_fault", fault,     1);
      chk("tmo_sticky_servo", servoCtrl, 0);
      req_valid = 1'b0;
      never_drop = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      #1;
      chk("tmo_clr_fault", fault,     0);
      chk("tmo_clr_ready", req_ready, 1);
      repeat (30) step();
`else
      back_extra = 100;
      issue("stall", 1);
      repeat (60) step();
      chk("stall_fault", fault, 0);
      chk("stall_busy",  busy,  1);
      chk("stall_servo", servoCtrl, 1);
      finish_req("stall", 1);
      back_extra = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
